// File: rtl/add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_pkg : shared width default and operand/result types for add      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package add_pkg;

  localparam int ADD_WIDTH_DEFAULT = 4;

  typedef logic [ADD_WIDTH_DEFAULT-1:0] operand_t;
  typedef logic [ADD_WIDTH_DEFAULT:0]   result_t;

endpackage : add_pkg
`default_nettype wire

// File: rtl/add_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_if : signal bundle for connecting add by name                    |
// | Rev 1.0   (carry_sticky present only with ADD_STICKY_CARRY_EN)      |
// +----------------------------------------------------------------------+
interface add_if
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input logic clk
);

  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             out_valid;
  logic             carry;
`ifdef ADD_STICKY_CARRY_EN
  logic             carry_sticky;
`endif

endinterface : add_if
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add : registered WIDTH-bit unsigned adder, one-cycle latency          |
// | Rev 1.0   optional sticky carry output under ADD_STICKY_CARRY_EN      |
// +----------------------------------------------------------------------+
module add
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             out_valid,
  output logic             carry
`ifdef ADD_STICKY_CARRY_EN
  ,
  output logic             carry_sticky
`endif
);

  logic [WIDTH:0] sum_next;

  // Operands are zero-extended first so the carry lands in the MSB.
  assign sum_next = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_next;
        carry <= sum_next[WIDTH];
      end
    end
  end

`ifdef ADD_STICKY_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_sticky <= 1'b0;
    end else if (in_valid && sum_next[WIDTH]) begin
      carry_sticky <= 1'b1;
    end
  end
`endif

endmodule : add
`default_nettype wire

// File: tb/tb_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_add : randomized self-checking bench for add (WIDTH 4 and 8)       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_add;

  localparam int W4 = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  add_if #(.WIDTH(W4)) bus (.clk(clk));

  logic          in_valid8;
  logic [W8-1:0] a8;
  logic [W8-1:0] b8;
  logic [W8:0]   sum8;
  logic          out_valid8;
  logic          carry8;
`ifdef ADD_STICKY_CARRY_EN
  logic          carry_sticky8;
`endif

  add #(.WIDTH(W4)) dut4 (
    .clk          (bus.clk),
    .rst_n        (bus.rst_n),
    .in_valid     (bus.in_valid),
    .a            (bus.a),
    .b            (bus.b),
    .sum          (bus.sum),
    .out_valid    (bus.out_valid),
    .carry        (bus.carry)
`ifdef ADD_STICKY_CARRY_EN
    ,
    .carry_sticky (bus.carry_sticky)
`endif
  );

  add #(.WIDTH(W8)) dut8 (
    .clk          (clk),
    .rst_n        (bus.rst_n),
    .in_valid     (in_valid8),
    .a            (a8),
    .b            (b8),
    .sum          (sum8),
    .out_valid    (out_valid8),
    .carry        (carry8)
`ifdef ADD_STICKY_CARRY_EN
    ,
    .carry_sticky (carry_sticky8)
`endif
  );

  // Reference model: last accepted result per instance, plain integer arithmetic.
  int m4_sum, m8_sum;
  bit m4_valid, m8_valid;
  bit m4_sticky, m8_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("sum4",   64'(bus.sum),       64'(m4_sum));
    check("valid4", 64'(bus.out_valid), 64'(m4_valid));
    check("carry4", 64'(bus.carry),     64'(m4_sum >= (1 << W4)));
    check("sum8",   64'(sum8),          64'(m8_sum));
    check("valid8", 64'(out_valid8),    64'(m8_valid));
    check("carry8", 64'(carry8),        64'(m8_sum >= (1 << W8)));
`ifdef ADD_STICKY_CARRY_EN
    check("sticky4", 64'(bus.carry_sticky), 64'(m4_sticky));
    check("sticky8", 64'(carry_sticky8),    64'(m8_sticky));
`endif
  endtask

  task automatic model_reset();
    m4_sum = 0; m4_valid = 0; m4_sticky = 0;
    m8_sum = 0; m8_valid = 0; m8_sticky = 0;
  endtask

  // Drive one edge's worth of inputs; operands go X when not valid.
  task automatic cycle(input bit v, input int x, input int y,
                       input bit v8 = 1'b0, input int x8 = 0, input int y8 = 0);
    bus.in_valid = v;
    bus.a = v ? 4'(x) : 'x;
    bus.b = v ? 4'(y) : 'x;
    in_valid8 = v8;
    a8 = v8 ? 8'(x8) : 'x;
    b8 = v8 ? 8'(y8) : 'x;
    @(posedge clk);
    #1;
    if (v) begin
      m4_sum = (x % (1 << W4)) + (y % (1 << W4));
      if (m4_sum >= (1 << W4)) m4_sticky = 1;
    end
    m4_valid = v;
    if (v8) begin
      m8_sum = (x8 % (1 << W8)) + (y8 % (1 << W8));
      if (m8_sum >= (1 << W8)) m8_sticky = 1;
    end
    m8_valid = v8;
    check_all();
  endtask

  initial begin
    bus.rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    model_reset();

    // Asynchronous reset, released between edges.
    #2 bus.rst_n = 1'b0;
    #1 check_all();
    @(posedge clk); #3;
    bus.rst_n = 1'b1;
    #4;

    cycle(1, 4, 4);
    check("req024_sum", 64'(bus.sum), 64'd8);

    cycle(1, 5, 6);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check("req025_hold", 64'(bus.sum), 64'd11);

    // Reset mid-stream, between edges, with a capture pending.
    #2;
    bus.in_valid = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
    bus.rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1;
    check_all();
    #2 bus.rst_n = 1'b1;
    cycle(1, 2, 3);

    cycle(1, 15, 15, 1, 255, 255);
    check("req026_max", 64'(bus.sum), 64'd30);
    cycle(1, 1, 1, 1, 1, 1);

    cycle(1, 1, 2);
    cycle(1, 7, 8);
    cycle(1, 0, 0);
    cycle(0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_add
`default_nettype wire
